// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and opcode constants for the instruction sequencer
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_LDR  = 3'b100;
   localparam logic [2:0] OP_STR  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_BRZ  = 3'b111;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic branch_conditional;
   } ctrl_t;

endpackage

// File: rtl/seq_timeout.sv
// rtl/seq_timeout.sv - memory-wait counter shared by the fetch and data phases
module seq_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != W'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // One more unacknowledged cycle would make TIMEOUT; the caller gates this with !ack.
   assign expired_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with timed memory handshakes
module seq_ctrl
   import seq_pkg::*;
#(
   parameter int PC_W    = 10,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [8:0]       instruction,
   input  logic [2:0]       alu_op,
   input  logic             reg_write,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             branch,
   input  logic             branch_conditional,
   input  logic             zero,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             ir_load,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             rf_we,
   output logic [2:0]       alu_op_q,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [2:0]       alu_op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_clr, tmo_inc, tmo_expired;
   logic             unused_ok;

   assign unused_ok = ^{instruction[5:0], PC_W > 0};

   seq_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (Clk),
      .rst       (Reset),
      .clr_i     (tmo_clr),
      .inc_i     (tmo_inc),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         ctrl_q   <= '0;
         alu_op_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         alu_op_q <= alu_op_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      alu_op_d = alu_op_q;
      if (state_q == S_DECODE) begin
         ctrl_d   = '{reg_write, mem_read, mem_write, branch, branch_conditional};
         alu_op_d = alu_op;
      end
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      pc_en    = 1'b0;
      pc_sel   = 1'b0;
      rf_we    = 1'b0;
      tmo_inc  = 1'b0;
      unique case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_expired) state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            state_d = (instruction[8:6] == OP_HALT) ? S_HALTED : S_EXEC;
         end
         S_EXEC: begin
            if (ctrl_q.mem_read || ctrl_q.mem_write) begin
               state_d = S_MEM;
            end else if (ctrl_q.branch) begin
               pc_en   = 1'b1;
               pc_sel  = !ctrl_q.branch_conditional || zero;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = ctrl_q.mem_write;
            if (dmem_ack) begin
               // Stores retire here; loads still need the register write.
               if (ctrl_q.mem_write) begin
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               tmo_inc = 1'b1;
               if (tmo_expired) state_d = S_ERROR;
            end
         end
         S_WB: begin
            rf_we   = ctrl_q.reg_write;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
      endcase
   end

   assign tmo_clr = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);

   assign busy = !((state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_ERROR));
   assign done = (state_q == S_HALTED);
   assign err  = (state_q == S_ERROR);

   always_comb begin
      cnt_d = cnt_q;
      if (((state_q == S_IDLE) || (state_q == S_HALTED)) && start) begin
         cnt_d = '0;
      end else if (busy && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl against a per-instruction phase model
module tb_seq_ctrl;
   import seq_pkg::*;

   localparam int TMO = 15;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

   logic        Clk = 1'b0;
   logic        Reset, start, zero, imem_ack, dmem_ack;
   logic [8:0]  instruction;
   logic [2:0]  alu_op;
   logic        reg_write, mem_read, mem_write, branch, branch_conditional;
   logic        imem_req, dmem_req, dmem_we, ir_load, pc_en, pc_sel, rf_we, busy, done, err;
   logic [2:0]  alu_op_q;
   logic [15:0] cycle_cnt;
   logic [9:0]  out_v;

   always #5 Clk = ~Clk;

   seq_ctrl #(.PC_W(10), .TIMEOUT(TMO), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .instruction(instruction), .alu_op(alu_op),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .branch_conditional(branch_conditional), .zero(zero), .imem_req(imem_req),
      .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we), .alu_op_q(alu_op_q),
      .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
   );

   assign out_v = {imem_req, ir_load, dmem_req, dmem_we, pc_en, pc_sel, rf_we, busy, done, err};

   typedef struct {
      logic        st, ia, da, z;
      logic [8:0]  ins;
      logic [2:0]  alu;
      logic [4:0]  fl;
      logic [9:0]  e;
      logic [2:0]  e_alu;
      logic [15:0] e_cnt;
   } cyc_t;

   // fl = {reg_write, mem_read, mem_write, branch, branch_conditional}
   typedef struct {
      logic [2:0] op;
      logic [2:0] alu;
      logic [4:0] fl;
      logic       z;
      int         lf;
      int         ld;
   } vec_t;

   cyc_t        trace[$];
   vec_t        dir[13];
   logic [15:0] m_cnt;
   logic [2:0]  m_aluq;
   int          m_mode;
   int          n_chk = 0, n_fail = 0, tcyc = 0;

   function automatic logic rb();
      return ($urandom_range(0, 1) == 1);
   endfunction

   function automatic logic [9:0] ev(input logic ireq, irl, dreq, dwe, pcen, pcsel, rfwe, bsy, dn, er);
      return {ireq, irl, dreq, dwe, pcen, pcsel, rfwe, bsy, dn, er};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, tcyc, act, exp_v);
      end
   endtask

   task automatic push(input logic [9:0] e, input logic st, ia, da, z, input logic dec,
                       input logic [8:0] ins, input logic [2:0] alu, input logic [4:0] fl);
      cyc_t c;
      c.st    = st;  c.ia = ia;  c.da = da;  c.z = z;
      c.ins   = dec ? ins : 9'($urandom);
      c.alu   = dec ? alu : 3'($urandom);
      c.fl    = dec ? fl  : 5'($urandom);
      c.e     = e;
      c.e_alu = m_aluq;
      c.e_cnt = m_cnt;
      if (e[2]) begin
         if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      end else if (st && !e[0]) begin
         m_cnt = '0;
      end
      trace.push_back(c);
   endtask

   task automatic park(input int n, input logic st);
      for (int i = 0; i < n; i++)
         push((m_mode == M_ERR) ? ev(0,0,0,0,0,0,0,0,0,1) :
              (m_mode == M_HALT) ? ev(0,0,0,0,0,0,0,0,1,0) : 10'b0,
              st, rb(), rb(), rb(), 1'b0, 9'd0, 3'd0, 5'd0);
   endtask

   task automatic do_start();
      push((m_mode == M_HALT) ? ev(0,0,0,0,0,0,0,0,1,0) : 10'b0,
           1'b1, rb(), rb(), rb(), 1'b0, 9'd0, 3'd0, 5'd0);
      m_mode = M_RUN;
   endtask

   // Expands one instruction into its expected per-cycle phases (starting in fetch).
   task automatic run_instr(input vec_t v);
      logic rw, mr, mw, br, bc, ack;
      logic [9:0] plain;
      {rw, mr, mw, br, bc} = v.fl;
      plain = ev(0,0,0,0,0,0,0,1,0,0);
      for (int k = 0; k <= v.lf; k++) begin
         if (k == TMO) begin m_mode = M_ERR; return; end
         ack = (k == v.lf);
         push(ev(1,ack,0,0,0,0,0,1,0,0), rb(), ack, rb(), rb(), 1'b0, 9'd0, 3'd0, 5'd0);
      end
      push(plain, rb(), rb(), rb(), rb(), 1'b1, {v.op, 6'($urandom)}, v.alu, v.fl);
      m_aluq = v.alu;
      if (v.op == OP_HALT) begin m_mode = M_HALT; return; end
      if (br && !(mr || mw)) begin
         push(ev(0,0,0,0,1,(!bc || v.z),0,1,0,0), rb(), rb(), rb(), v.z, 1'b0, 9'd0, 3'd0, 5'd0);
         return;
      end
      push(plain, rb(), rb(), rb(), rb(), 1'b0, 9'd0, 3'd0, 5'd0);
      if (mr || mw) begin
         for (int k = 0; k <= v.ld; k++) begin
            if (k == TMO) begin m_mode = M_ERR; return; end
            ack = (k == v.ld);
            push(ev(0,0,1,mw,(ack && mw),0,0,1,0,0), rb(), rb(), ack, rb(), 1'b0, 9'd0, 3'd0, 5'd0);
         end
         if (mw) return;
      end
      push(ev(0,0,0,0,1,0,rw,1,0,0), rb(), rb(), rb(), rb(), 1'b0, 9'd0, 3'd0, 5'd0);
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.op  = 3'($urandom);
      if (v.op == OP_HALT) v.op = OP_ADD;
      v.alu = 3'($urandom);
      v.fl  = 5'($urandom);
      v.z   = rb();
      v.lf  = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3);
      v.ld  = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3);
      return v;
   endfunction

   task automatic play();
      while (trace.size() > 0) begin
         cyc_t c;
         c = trace.pop_front();
         @(posedge Clk); #1;
         start = c.st;  imem_ack = c.ia;  dmem_ack = c.da;  zero = c.z;
         instruction = c.ins;  alu_op = c.alu;
         {reg_write, mem_read, mem_write, branch, branch_conditional} = c.fl;
         @(negedge Clk);
         chk("outputs", 32'(out_v), 32'(c.e));
         chk("alu_op_q", 32'(alu_op_q), 32'(c.e_alu));
         chk("cycle_cnt", 32'(cycle_cnt), 32'(c.e_cnt));
         tcyc++;
      end
   endtask

   task automatic model_reset();
      m_cnt = '0;  m_aluq = '0;  m_mode = M_IDLE;
   endtask

   initial begin
      logic got;
      Reset = 1'b1;  start = 0;  zero = 0;  imem_ack = 0;  dmem_ack = 0;
      instruction = '0;  alu_op = '0;
      {reg_write, mem_read, mem_write, branch, branch_conditional} = '0;

      dir[0]  = '{OP_ADD,  3'b000, 5'b10000, 1'b0, 0, 0};
      dir[1]  = '{OP_SUB,  3'b001, 5'b10000, 1'b0, 2, 0};
      dir[2]  = '{OP_LDR,  3'b000, 5'b11000, 1'b0, 0, 3};
      dir[3]  = '{OP_STR,  3'b000, 5'b00100, 1'b0, 0, 0};
      dir[4]  = '{OP_BRZ,  3'b111, 5'b00011, 1'b1, 0, 0};
      dir[5]  = '{OP_BRZ,  3'b111, 5'b00011, 1'b0, 0, 0};
      dir[6]  = '{3'b010,  3'b010, 5'b00000, 1'b0, 0, 0};
      dir[7]  = '{3'b011,  3'b101, 5'b10000, 1'b0, 1, 0};
      dir[8]  = '{OP_ADD,  3'b110, 5'b10000, 1'b0, TMO - 1, 0};
      dir[9]  = '{OP_LDR,  3'b011, 5'b11000, 1'b0, 0, TMO - 1};
      dir[10] = '{OP_STR,  3'b100, 5'b00100, 1'b0, 1, 2};
      dir[11] = '{3'b010,  3'b001, 5'b00010, 1'b0, 0, 0};
      dir[12] = '{OP_HALT, 3'b010, 5'b11111, 1'b1, 0, 0};

      repeat (2) @(negedge Clk);
      chk("reset_outputs", 32'(out_v), 32'd0);
      chk("reset_alu_op_q", 32'(alu_op_q), 32'd0);
      chk("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
      @(posedge Clk); #1 Reset = 1'b0;

      // Directed program, halt/restart, then fetch timeout into sticky error.
      model_reset();
      park(2, 1'b0);
      do_start();
      for (int i = 0; i < 13; i++) run_instr(dir[i]);
      park(3, 1'b0);
      do_start();
      run_instr('{OP_STR, 3'b000, 5'b00100, 1'b0, TMO + 5, 0});
      park(5, 1'b1);
      play();

      // Reset abandons an outstanding data request.
      @(posedge Clk); #1 Reset = 1'b1;  start = 0;  imem_ack = 0;  dmem_ack = 0;
      @(posedge Clk); #1 Reset = 1'b0;
      @(posedge Clk); #1 start = 1'b1;
      @(posedge Clk); #1 start = 1'b0;  imem_ack = 1'b1;  instruction = 9'b100000000;
      alu_op = 3'b101;
      {reg_write, mem_read, mem_write, branch, branch_conditional} = 5'b11000;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge Clk);
         if (dmem_req) got = 1'b1;
      end
      chk("mem_reached_before_reset", 32'(got), 32'd1);
      #1 Reset = 1'b1;
      #1;
      chk("async_reset_dmem_req", 32'(dmem_req), 32'd0);
      chk("async_reset_outputs", 32'(out_v), 32'd0);
      chk("async_reset_alu_op_q", 32'(alu_op_q), 32'd0);
      chk("async_reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
      @(posedge Clk); #1 Reset = 1'b0;  imem_ack = 0;
      repeat (3) begin
         @(negedge Clk);
         chk("idle_after_reset", 32'(out_v), 32'd0);
      end

      // Randomized programs against the phase model, ending in a data timeout.
      model_reset();
      park(2, 1'b0);
      do_start();
      for (int i = 0; i < 80; i++) run_instr(rand_vec());
      run_instr('{OP_HALT, 3'($urandom), 5'($urandom), 1'b0, 0, 0});
      park(2, 1'b0);
      do_start();
      for (int i = 0; i < 30; i++) run_instr(rand_vec());
      run_instr('{OP_LDR, 3'b000, 5'b11000, 1'b0, 0, TMO});
      park(3, 1'b1);
      play();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
